// File: rtl/mac_tx_feeder.sv
// mac_tx_feeder: MAC-side frame source for the OFDM transmitter.
// The host loads payload bytes into a byte FIFO and then submits a frame
// descriptor. The block raises txstart_req for the PHY and serves one byte
// for each din_req cycle, one cycle later. It then waits for the PHY to go
// idle and pulses tx_done. Error flags stay set until the next descriptor.
module mac_tx_feeder #(
   parameter int FIFO_AW    = 12,
   parameter int REQ_CYCLES = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic               mac_clk,
   input  logic               sys_rst_n,
   input  logic               host_wr_en,
   input  logic [7:0]         host_wr_data,
   output logic               fifo_full,
   output logic [FIFO_AW:0]   fifo_level,
   input  logic               frm_valid,
   input  logic [11:0]        frm_len,
   input  logic [5:0]         frm_rate,
   input  logic [2:0]         frm_txpwr,
   output logic               frm_ready,
   output logic               txstart_req,
   output logic [20:0]        tx_param,
   input  logic               phy_status,
   input  logic               din_req,
   output logic [7:0]         din,
   output logic               din_vld,
   output logic               tx_done,
   output logic [2:0]         err
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int LW    = FIFO_AW + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int RW    = $clog2(REQ_CYCLES + 1);

   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_STREAM    = 3'd3,
      ST_WAIT_DONE = 3'd4
   } state_t;

   logic [7:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   state_t             state_r;
   logic [RW-1:0]      req_cnt_r;
   logic [TW-1:0]      tmo_cnt_r;
   logic [11:0]        sent_r;

   logic [11:0]        len_s;
   logic               stream_act_s;
   logic               fifo_empty_s;
   logic               serve_s;
   logic               rd_s;
   logic               wr_s;
   logic               underrun_s;
   logic               tmo_hit_s;
   logic [LW-1:0]      level_nxt_s;

   assign len_s = tx_param[20:9];

   // Decide which byte moves this cycle and what the FIFO level becomes.
   always_comb begin
      stream_act_s = 1'b0;
      case (state_r)
         ST_WAIT_BUSY, ST_STREAM, ST_WAIT_DONE: stream_act_s = 1'b1;
         default:                               stream_act_s = 1'b0;
      endcase
      fifo_empty_s = (fifo_level == {LW{1'b0}});
      serve_s      = din_req & stream_act_s & (sent_r != len_s);
      rd_s         = serve_s & ~fifo_empty_s;
      underrun_s   = serve_s & fifo_empty_s;
      // A read in the same cycle frees a slot, so a write at full is still accepted
      wr_s         = host_wr_en & (~fifo_full | rd_s);
      tmo_hit_s    = (tmo_cnt_r == TW'(TIMEOUT - 1));
      if (wr_s && !rd_s) begin
         level_nxt_s = fifo_level + LVL_ONE;
      end else if (rd_s && !wr_s) begin
         level_nxt_s = fifo_level - LVL_ONE;
      end else begin
         level_nxt_s = fifo_level;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge mac_clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= host_wr_data;
      end
   end

   // FIFO pointers, level and full flag; pointers wrap modulo depth.
   always_ff @(posedge mac_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_r   <= {FIFO_AW{1'b0}};
         rd_ptr_r   <= {FIFO_AW{1'b0}};
         fifo_level <= {LW{1'b0}};
         fifo_full  <= 1'b0;
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
         end
         if (rd_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
         end
         fifo_level <= level_nxt_s;
         fifo_full  <= (level_nxt_s == LVL_FULL);
      end
   end

   // Frame sequencer with registered PHY handshake, byte stream and status.
   always_ff @(posedge mac_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= ST_IDLE;
         frm_ready   <= 1'b1;
         txstart_req <= 1'b0;
         tx_param    <= 21'd0;
         din         <= 8'h00;
         din_vld     <= 1'b0;
         tx_done     <= 1'b0;
         err         <= 3'b000;
         req_cnt_r   <= {RW{1'b0}};
         tmo_cnt_r   <= {TW{1'b0}};
         sent_r      <= 12'd0;
      end else begin
         tx_done <= 1'b0;
         din_vld <= serve_s;
         din     <= rd_s ? mem_r[rd_ptr_r] : 8'h00;
         if (serve_s) begin
            sent_r <= sent_r + 12'd1;
         end
         err <= err | {1'b0, underrun_s, 1'b0};
         case (state_r)
            ST_IDLE: begin
               if (frm_valid && frm_ready) begin
                  tx_param <= {frm_len, frm_rate, frm_txpwr};
                  sent_r   <= 12'd0;
                  if (frm_len == 12'd0) begin
                     // Nothing to send: flag it and finish without waking the PHY
                     err     <= 3'b001;
                     tx_done <= 1'b1;
                  end else begin
                     err         <= 3'b000;
                     state_r     <= ST_START;
                     frm_ready   <= 1'b0;
                     txstart_req <= 1'b1;
                     req_cnt_r   <= {RW{1'b0}};
                  end
               end
            end
            ST_START: begin
               if (req_cnt_r == RW'(REQ_CYCLES - 1)) begin
                  txstart_req <= 1'b0;
                  state_r     <= ST_WAIT_BUSY;
                  tmo_cnt_r   <= {TW{1'b0}};
               end else begin
                  req_cnt_r <= req_cnt_r + RW'(1);
               end
            end
            ST_WAIT_BUSY: begin
               if (phy_status) begin
                  state_r <= ST_STREAM;
               end else if (tmo_hit_s) begin
                  err       <= err | {1'b1, underrun_s, 1'b0};
                  tx_done   <= 1'b1;
                  frm_ready <= 1'b1;
                  state_r   <= ST_IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            ST_STREAM: begin
               if (!phy_status) begin
                  // PHY aborted the frame; unsent bytes stay in the FIFO
                  tx_done   <= 1'b1;
                  frm_ready <= 1'b1;
                  state_r   <= ST_IDLE;
               end else if (sent_r == len_s) begin
                  state_r   <= ST_WAIT_DONE;
                  tmo_cnt_r <= {TW{1'b0}};
               end
            end
            ST_WAIT_DONE: begin
               if (!phy_status) begin
                  tx_done   <= 1'b1;
                  frm_ready <= 1'b1;
                  state_r   <= ST_IDLE;
               end else if (tmo_hit_s) begin
                  err       <= err | {1'b1, underrun_s, 1'b0};
                  tx_done   <= 1'b1;
                  frm_ready <= 1'b1;
                  state_r   <= ST_IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               frm_ready   <= 1'b1;
               txstart_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx_feeder.sv
// Directed testbench for mac_tx_feeder. Inputs change 1 ns after a rising edge.
// Outputs are sampled at the same point, so each sample shows the state left
// by the edge just taken.
module tb_mac_tx_feeder;

   logic        mac_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        host_wr_en = 1'b0;
   logic [7:0]  host_wr_data = 8'h00;
   logic        fifo_full;
   logic [12:0] fifo_level;
   logic        frm_valid = 1'b0;
   logic [11:0] frm_len = 12'd0;
   logic [5:0]  frm_rate = 6'd0;
   logic [2:0]  frm_txpwr = 3'd0;
   logic        frm_ready;
   logic        txstart_req;
   logic [20:0] tx_param;
   logic        phy_status = 1'b0;
   logic        din_req = 1'b0;
   logic [7:0]  din;
   logic        din_vld;
   logic        tx_done;
   logic [2:0]  err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 mac_clk = ~mac_clk;

   mac_tx_feeder #(.FIFO_AW(12), .REQ_CYCLES(2), .TIMEOUT(1024)) dut (
      .mac_clk(mac_clk), .sys_rst_n(sys_rst_n),
      .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
      .fifo_full(fifo_full), .fifo_level(fifo_level),
      .frm_valid(frm_valid), .frm_len(frm_len), .frm_rate(frm_rate), .frm_txpwr(frm_txpwr),
      .frm_ready(frm_ready), .txstart_req(txstart_req), .tx_param(tx_param),
      .phy_status(phy_status), .din_req(din_req), .din(din), .din_vld(din_vld),
      .tx_done(tx_done), .err(err)
   );

   task automatic step();
      @(posedge mac_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0; host_wr_en = 1'b0; frm_valid = 1'b0;
      phy_status = 1'b0; din_req = 1'b0;
      step(); step();
      sys_rst_n = 1'b1;
      step();
   endtask

   task automatic preload(input int n, input logic [7:0] first);
      host_wr_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         host_wr_data = first + 8'(i);
         step();
      end
      host_wr_en = 1'b0;
   endtask

   task automatic submit(input logic [11:0] len, input logic [5:0] rate, input logic [2:0] pwr);
      frm_valid = 1'b1; frm_len = len; frm_rate = rate; frm_txpwr = pwr;
      step();
      frm_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({frm_ready, txstart_req, din_vld, tx_done, fifo_full} !== 5'b10000) begin
         n_fail++; $display("FAIL reset_flags: got %b want %b", {frm_ready, txstart_req, din_vld, tx_done, fifo_full}, 5'b10000);
      end
      n_checks++;
      if (tx_param !== 21'd0) begin n_fail++; $display("FAIL reset_tx_param: got %h want 0", tx_param); end
      n_checks++;
      if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", err); end
      n_checks++;
      if (fifo_level !== 13'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
   endtask

   task automatic test_main_frame();
      int cnt;
      int sent;
      int pulses;
      logic req;
      logic exp_vld;
      logic [4:0] pat;
      pat = 5'b01101;   // din_req for the first five cycles: 1,0,1,1,0
      do_reset();
      preload(360, 8'h55);
      n_checks++;
      if (fifo_level !== 13'd360) begin n_fail++; $display("FAIL main_preload_level: got %0d want 360", fifo_level); end
      submit(12'd357, 6'd36, 3'd0);
      n_checks++;
      if (tx_param !== {12'd357, 6'd36, 3'd0}) begin n_fail++; $display("FAIL main_tx_param: got %h want %h", tx_param, {12'd357, 6'd36, 3'd0}); end
      n_checks++;
      if (frm_ready !== 1'b0) begin n_fail++; $display("FAIL main_frm_ready_busy: got %b want 0", frm_ready); end
      cnt = 0;
      while (txstart_req === 1'b1 && cnt < 10) begin cnt++; step(); end
      n_checks++;
      if (cnt != 2) begin n_fail++; $display("FAIL main_txstart_len: got %0d cycles want 2", cnt); end
      phy_status = 1'b1;
      step();
      sent = 0;
      for (int c = 0; c < 365; c++) begin
         req = (c < 5) ? pat[c] : 1'b1;
         din_req = req;
         step();
         exp_vld = req && (sent < 357);
         n_checks++;
         if (din_vld !== exp_vld) begin n_fail++; $display("FAIL main_din_vld c=%0d: got %b want %b", c, din_vld, exp_vld); end
         if (exp_vld) begin
            n_checks++;
            if (din !== 8'(8'h55 + sent)) begin n_fail++; $display("FAIL main_din byte=%0d: got %h want %h", sent, din, 8'(8'h55 + sent)); end
            sent++;
         end
      end
      din_req = 1'b0;
      n_checks++;
      if (fifo_level !== 13'd3) begin n_fail++; $display("FAIL main_end_level: got %0d want 3", fifo_level); end
      n_checks++;
      if (tx_param !== {12'd357, 6'd36, 3'd0}) begin n_fail++; $display("FAIL main_tx_param_stable: got %h", tx_param); end
      n_checks++;
      if (tx_done !== 1'b0) begin n_fail++; $display("FAIL main_early_done: got %b want 0", tx_done); end
      phy_status = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin step(); if (tx_done === 1'b1) pulses++; end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL main_tx_done_count: got %0d want 1", pulses); end
      n_checks++;
      if (err !== 3'b000) begin n_fail++; $display("FAIL main_err: got %b want 000", err); end
      n_checks++;
      if (frm_ready !== 1'b1) begin n_fail++; $display("FAIL main_frm_ready_idle: got %b want 1", frm_ready); end
   endtask

   task automatic test_underrun();
      int cnt;
      int sent;
      int pulses;
      logic [7:0] exp_b;
      do_reset();
      preload(10, 8'hA0);
      submit(12'd12, 6'd5, 3'd3);
      cnt = 0;
      while (txstart_req === 1'b1 && cnt < 10) begin cnt++; step(); end
      n_checks++;
      if (cnt != 2) begin n_fail++; $display("FAIL under_txstart_len: got %0d want 2", cnt); end
      phy_status = 1'b1;
      step();
      sent = 0;
      for (int c = 0; c < 16; c++) begin
         din_req = 1'b1;
         step();
         n_checks++;
         if (din_vld !== (sent < 12)) begin n_fail++; $display("FAIL under_din_vld c=%0d: got %b want %b", c, din_vld, (sent < 12)); end
         if (sent < 12) begin
            exp_b = (sent < 10) ? 8'(8'hA0 + sent) : 8'h00;
            n_checks++;
            if (din !== exp_b) begin n_fail++; $display("FAIL under_din byte=%0d: got %h want %h", sent, din, exp_b); end
            sent++;
         end
      end
      din_req = 1'b0;
      phy_status = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin step(); if (tx_done === 1'b1) pulses++; end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL under_tx_done_count: got %0d want 1", pulses); end
      n_checks++;
      if (err !== 3'b010) begin n_fail++; $display("FAIL under_err: got %b want 010", err); end
      n_checks++;
      if (fifo_level !== 13'd0) begin n_fail++; $display("FAIL under_level: got %0d want 0", fifo_level); end
   endtask

   task automatic test_zero_len();
      submit(12'd0, 6'd1, 3'd1);
      n_checks++;
      if (tx_done !== 1'b1) begin n_fail++; $display("FAIL zero_tx_done: got %b want 1", tx_done); end
      n_checks++;
      if (err !== 3'b001) begin n_fail++; $display("FAIL zero_err: got %b want 001", err); end
      n_checks++;
      if ({frm_ready, txstart_req} !== 2'b10) begin n_fail++; $display("FAIL zero_ready_start: got %b want 10", {frm_ready, txstart_req}); end
      n_checks++;
      if (tx_param !== {12'd0, 6'd1, 3'd1}) begin n_fail++; $display("FAIL zero_tx_param: got %h want %h", tx_param, {12'd0, 6'd1, 3'd1}); end
      step();
      n_checks++;
      if ({tx_done, txstart_req, frm_ready} !== 3'b001) begin n_fail++; $display("FAIL zero_after: got %b want 001", {tx_done, txstart_req, frm_ready}); end
   endtask

   task automatic test_timeout();
      int cnt;
      int k;
      phy_status = 1'b0;
      submit(12'd5, 6'd2, 3'd0);
      n_checks++;
      if (err !== 3'b000) begin n_fail++; $display("FAIL tmo_err_cleared: got %b want 000", err); end
      cnt = 0;
      while (txstart_req === 1'b1 && cnt < 10) begin cnt++; step(); end
      k = 0;
      while (k < 1100) begin
         step();
         k++;
         if (tx_done === 1'b1) break;
      end
      n_checks++;
      if (k != 1024) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles want 1024", k); end
      n_checks++;
      if (err !== 3'b100) begin n_fail++; $display("FAIL tmo_err: got %b want 100", err); end
      n_checks++;
      if ({frm_ready, txstart_req} !== 2'b10) begin n_fail++; $display("FAIL tmo_idle: got %b want 10", {frm_ready, txstart_req}); end
      submit(12'd7, 6'd3, 3'd1);
      n_checks++;
      if ({err, txstart_req} !== 4'b0001) begin n_fail++; $display("FAIL tmo_next_accept: got %b want 0001", {err, txstart_req}); end
   endtask

   task automatic test_fifo_full_and_reset();
      int cnt;
      do_reset();
      preload(4096, 8'h03);
      n_checks++;
      if ({fifo_full, fifo_level} !== {1'b1, 13'd4096}) begin n_fail++; $display("FAIL full_fill: got full=%b level=%0d want 1/4096", fifo_full, fifo_level); end
      preload(1, 8'hEE);
      n_checks++;
      if ({fifo_full, fifo_level} !== {1'b1, 13'd4096}) begin n_fail++; $display("FAIL full_overflow: got full=%b level=%0d want 1/4096", fifo_full, fifo_level); end
      submit(12'd4095, 6'd9, 3'd2);
      cnt = 0;
      while (txstart_req === 1'b1 && cnt < 10) begin cnt++; step(); end
      phy_status = 1'b1;
      step();
      din_req = 1'b1; host_wr_en = 1'b1; host_wr_data = 8'hEE;
      step();
      host_wr_en = 1'b0;
      n_checks++;
      if ({din_vld, din} !== {1'b1, 8'h03}) begin n_fail++; $display("FAIL full_rw_byte: got vld=%b din=%h want 1/03", din_vld, din); end
      n_checks++;
      if (fifo_level !== 13'd4096) begin n_fail++; $display("FAIL full_rw_level: got %0d want 4096", fifo_level); end
      step(); step(); step();
      n_checks++;
      if ({din_vld, din, fifo_level} !== {1'b1, 8'h06, 13'd4093}) begin n_fail++; $display("FAIL full_stream: got vld=%b din=%h level=%0d want 1/06/4093", din_vld, din, fifo_level); end
      #2;
      sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({frm_ready, txstart_req, din_vld, tx_done, fifo_full} !== 5'b10000) begin n_fail++; $display("FAIL midrst_flags: got %b want 10000", {frm_ready, txstart_req, din_vld, tx_done, fifo_full}); end
      n_checks++;
      if ({tx_param, err, din} !== 32'd0) begin n_fail++; $display("FAIL midrst_values: got %h want 0", {tx_param, err, din}); end
      n_checks++;
      if (fifo_level !== 13'd0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
      din_req = 1'b0; phy_status = 1'b0;
      step();
      sys_rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_main_frame();
      test_underrun();
      test_zero_len();
      test_timeout();
      test_fifo_full_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
